// File: rtl/muldiv_pkg.sv
// muldiv_pkg: HI/LO op encodings and muldiv FSM state constants
package muldiv_pkg;
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: combinational 64-bit product or quotient/remainder with signed and zero-divisor rules
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);
  logic        sgn;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] mag_a, mag_b, uq, ur, q, r;
  always_comb begin
    sgn = (op == MD_MULT) || (op == MD_DIV);
    ext_a = {{32{sgn & a[31]}}, a};
    ext_b = {{32{sgn & b[31]}}, b};
    prod = ext_a * ext_b;
    mag_a = (sgn && a[31]) ? -a : a;
    mag_b = (sgn && b[31]) ? -b : b;
    div_zero = (b == 32'd0);
    uq = mag_a / (div_zero ? 32'd1 : mag_b);
    ur = mag_a % (div_zero ? 32'd1 : mag_b);
    q = (sgn && (a[31] ^ b[31])) ? -uq : uq;
    r = (sgn && a[31]) ? -ur : ur;
    res_hi = op[1] ? r : prod[63:32];
    res_lo = op[1] ? q : prod[31:0];
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle mult/div FSM holding architectural HI/LO beside the E stage
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        md_hazard,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
  logic        dz_q, dz_d;
  logic [31:0] core_hi, core_lo;
  logic        core_dz;
  muldiv_core u_core (.op(op), .a(src_a), .b(src_b), .res_hi(core_hi), .res_lo(core_lo), .div_zero(core_dz));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    phi_d = phi_q;
    plo_d = plo_q;
    dz_d = dz_q;
    if (state_q == S_IDLE) begin
      if (start && !op[2]) begin
        state_d = op[1] ? S_DIV : S_MUL;
        cnt_d = op[1] ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
        phi_d = core_hi;
        plo_d = core_lo;
        dz_d = op[1] & core_dz;
      end
      hi_d = (start && op == MD_MTHI) ? src_a : hi_q;
      lo_d = (start && op == MD_MTLO) ? src_a : lo_q;
    end else begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = S_IDLE;
        hi_d = dz_q ? hi_q : phi_q;
        lo_d = dz_q ? lo_q : plo_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      phi_q <= '0;
      plo_q <= '0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      dz_q <= dz_d;
    end
  end
  assign busy = (state_q != S_IDLE);
  assign md_hazard = busy | (start & ~op[2]);
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit timing, arithmetic and HI/LO behaviour
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, md_hazard;
  logic [31:0] hi, lo;
  int checks = 0;
  int errors = 0;
  logic allow_overlap = 1'b0;
  muldiv_unit dut (.clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
                   .busy(busy), .md_hazard(md_hazard), .hi(hi), .lo(lo));
  always #5 clk = ~clk;
  always @(negedge clk)
    assert (!(reset && !allow_overlap && start && busy)) else begin
      errors++;
      $display("FAIL start_while_busy: start=1 busy=1 at %0t", $time);
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
    op = 3'd7;
  endtask
  task automatic run_busy(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask
  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || md_hazard !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset: busy=%b haz=%b hi=%h lo=%h want 0 0 0 0", busy, md_hazard, hi, lo);
    end
    reset = 1'b1;
    tick();
  endtask
  task automatic test_mult();
    int n;
    start = 1'b1;
    op = 3'd0;
    src_a = 32'hFFFFFFFE;
    src_b = 32'd3;
    #1;
    checks++;
    if (md_hazard !== 1'b1) begin
      errors++;
      $display("FAIL mult_hazard: md_hazard=%b want 1", md_hazard);
    end
    tick();
    start = 1'b0;
    op = 3'd7;
    checks++;
    if (busy !== 1'b1 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL mult_hold: busy=%b hi=%h lo=%h want 1 0 0", busy, hi, lo);
    end
    run_busy(n);
    checks++;
    if (n !== 5 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL mult: cycles=%0d hi=%h lo=%h want 5 ffffffff fffffffa", n, hi, lo);
    end
  endtask
  task automatic test_multu();
    int n;
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_busy(n);
    checks++;
    if (n !== 5 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      errors++;
      $display("FAIL multu: cycles=%0d hi=%h lo=%h want 5 fffffffe 00000001", n, hi, lo);
    end
  endtask
  task automatic test_div();
    int n;
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    run_busy(n);
    checks++;
    if (n !== 10 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL div_neg: cycles=%0d hi=%h lo=%h want 10 ffffffff fffffffd", n, hi, lo);
    end
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_busy(n);
    checks++;
    if (n !== 10 || hi !== 32'd0 || lo !== 32'h80000000) begin
      errors++;
      $display("FAIL div_ovf: cycles=%0d hi=%h lo=%h want 10 00000000 80000000", n, hi, lo);
    end
    issue(3'd2, 32'd7, 32'hFFFFFFFE);
    run_busy(n);
    checks++;
    if (hi !== 32'd1 || lo !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL div_negdiv: hi=%h lo=%h want 00000001 fffffffd", hi, lo);
    end
  endtask
  task automatic test_mthi_mtlo();
    int n;
    start = 1'b1;
    op = 3'd4;
    src_a = 32'h12345678;
    #1;
    checks++;
    if (md_hazard !== 1'b0) begin
      errors++;
      $display("FAIL mt_hazard: md_hazard=%b want 0", md_hazard);
    end
    tick();
    op = 3'd5;
    src_a = 32'd9;
    checks++;
    if (hi !== 32'h12345678 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi: hi=%h busy=%b want 12345678 0", hi, busy);
    end
    tick();
    start = 1'b0;
    op = 3'd7;
    checks++;
    if (lo !== 32'd9 || hi !== 32'h12345678 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: hi=%h lo=%h busy=%b want 12345678 00000009 0", hi, lo, busy);
    end
    issue(3'd6, 32'hAAAAAAAA, 32'd1);
    checks++;
    if (busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'd9) begin
      errors++;
      $display("FAIL noop: busy=%b hi=%h lo=%h want 0 12345678 00000009", busy, hi, lo);
    end
    issue(3'd3, 32'd100, 32'd0);
    run_busy(n);
    checks++;
    if (n !== 10 || hi !== 32'h12345678 || lo !== 32'd9) begin
      errors++;
      $display("FAIL divu_zero: cycles=%0d hi=%h lo=%h want 10 12345678 00000009", n, hi, lo);
    end
  endtask
  task automatic test_overlap();
    int n;
    allow_overlap = 1'b1;
    issue(3'd0, 32'd100, 32'd3);
    src_a = 32'd55;
    src_b = 32'd66;
    n = 0;
    while (busy && n < 40) begin
      n++;
      start = (n == 2);
      op = (n == 2) ? 3'd4 : 3'd7;
      src_a = n[0] ? 32'hDEADBEEF : 32'd11;
      tick();
    end
    start = 1'b0;
    op = 3'd7;
    allow_overlap = 1'b0;
    checks++;
    if (n !== 5 || hi !== 32'd0 || lo !== 32'd300) begin
      errors++;
      $display("FAIL overlap: cycles=%0d hi=%h lo=%h want 5 00000000 0000012c", n, hi, lo);
    end
  endtask
  task automatic test_reset_mid();
    int n;
    issue(3'd2, 32'd100, 32'd7);
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    issue(3'd0, 32'd6, 32'd7);
    run_busy(n);
    checks++;
    if (n !== 5 || hi !== 32'd0 || lo !== 32'd42) begin
      errors++;
      $display("FAIL mult_after_reset: cycles=%0d hi=%h lo=%h want 5 0 0000002a", n, hi, lo);
    end
  endtask
  task automatic test_back_to_back();
    int n;
    issue(3'd3, 32'd100, 32'd7);
    run_busy(n);
    checks++;
    if (n !== 10 || hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL divu: cycles=%0d hi=%h lo=%h want 10 00000002 0000000e", n, hi, lo);
    end
    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_busy(n);
    checks++;
    if (n !== 5 || hi !== 32'd0 || lo !== 32'd1) begin
      errors++;
      $display("FAIL back_to_back: cycles=%0d hi=%h lo=%h want 5 0 00000001", n, hi, lo);
    end
  endtask
  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_mthi_mtlo();
    test_overlap();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
